// File: rtl/fb_pkg.sv
// Shared types and helpers for the region framebuffer.
package fb_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    RENDER    = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_t;

  // Address bits needed to cover a region of 'area' pixels.
  function automatic int fb_addr_w(input int area);
    return (area <= 1) ? 1 : $clog2(area);
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One framebuffer bank: simple dual-port RAM, single clock, registered
// read-first output. Contents are deliberately never reset.
module fb_bank_ram #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 91500
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read in one block: a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/region_framebuffer.sv
// Region framebuffer: a renderer writes RGB pixels into a rectangular region,
// a VGA scan reads them back with a fixed RD_LAT pipeline.
// Build option: define DOUBLE_BUFFER_EN for two banks with frame swapping;
// otherwise a single bank is shared by the renderer and the display.
module region_framebuffer
  import fb_pkg::*;
#(
  parameter int START_X = 390,
  parameter int START_Y = 390,
  parameter int END_X   = 634,
  parameter int END_Y   = 765,
  parameter int CHAN_W  = 4,
  parameter int RD_LAT  = 2,
  parameter logic [3*CHAN_W-1:0] BG_COLOR = '0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [HCOUNT_W-1:0] wr_hcount,
  input  logic [VCOUNT_W-1:0] wr_vcount,
  input  logic [23:0]         wr_pixel,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                frame_done,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                ad_in,
  input  logic                nf_in,
  output logic [CHAN_W-1:0]   vga_r,
  output logic [CHAN_W-1:0]   vga_g,
  output logic [CHAN_W-1:0]   vga_b,
  output logic                hs_out,
  output logic                vs_out,
  output logic                swap_pending,
  output logic [15:0]         frames_shown,
  output logic [15:0]         oob_drops
);

  localparam int REGION_W = END_X - START_X;
  localparam int REGION_H = END_Y - START_Y;
  localparam int AREA     = REGION_W * REGION_H;
  localparam int ADDR_W   = fb_addr_w(AREA);
  localparam int PIX_W    = 3 * CHAN_W;
`ifdef DOUBLE_BUFFER_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  function automatic logic in_region(input logic [HCOUNT_W-1:0] h, input logic [VCOUNT_W-1:0] v);
    return (int'(h) >= START_X) && (int'(h) < END_X) && (int'(v) >= START_Y) && (int'(v) < END_Y);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [HCOUNT_W-1:0] h, input logic [VCOUNT_W-1:0] v);
    int a;
    a = (int'(h) - START_X) + (int'(v) - START_Y) * REGION_W;
    return ADDR_W'(a);
  endfunction

  rgb888_t            wr_rgb;
  logic               wr_in_region, wr_accept, wr_en, rd_in_region;
  logic [PIX_W-1:0]   wr_word, ram_q, data_out, colour;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [NUM_BANKS-1:0] bank_we;
  logic [PIX_W-1:0]   bank_q [NUM_BANKS];
  logic [15:0]        frames_reg, oob_reg;
  logic [3:0]         fpipe [RD_LAT];  // {hs, vs, ad, in_region}
  logic               unused_ok;

  assign wr_rgb       = wr_pixel;
  assign wr_word      = {wr_rgb.r[7 -: CHAN_W], wr_rgb.g[7 -: CHAN_W], wr_rgb.b[7 -: CHAN_W]};
  assign wr_in_region = in_region(wr_hcount, wr_vcount);
  assign wr_accept    = wr_valid && wr_ready;
  assign wr_en        = wr_accept && wr_in_region;
  assign wr_addr      = pix_addr(wr_hcount, wr_vcount);
  assign rd_in_region = in_region(hcount_in, vcount_in);
  assign rd_addr      = rd_in_region ? pix_addr(hcount_in, vcount_in) : '0;
  // Low channel bits are intentionally discarded; nf_in is idle in single-bank builds.
  assign unused_ok    = ^{wr_rgb, nf_in};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      fb_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(PIX_W), .DEPTH(AREA)) u_ram (
        .clk     (aclk),
        .we      (bank_we[gi]),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (bank_q[gi])
      );
    end
  endgenerate

`ifdef DOUBLE_BUFFER_EN
  fb_state_t   state_reg, state_next;
  logic        disp_bank_reg, disp_bank_next, disp_d_reg;
  logic [15:0] frames_next;

  // Write-side FSM state, display bank and swap counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= RENDER;
      disp_bank_reg <= 1'b0;
      disp_d_reg    <= 1'b0;
      frames_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      disp_bank_reg <= disp_bank_next;
      disp_d_reg    <= disp_bank_reg;
      frames_reg    <= frames_next;
    end
  end

  // Next-state: frame_done parks the renderer, the next nf_in swaps banks.
  always_comb begin
    state_next     = state_reg;
    disp_bank_next = disp_bank_reg;
    frames_next    = frames_reg;
    wr_ready       = 1'b1;
    swap_pending   = 1'b0;
    case (state_reg)
      RENDER: begin
        if (frame_done) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        wr_ready     = 1'b0;
        swap_pending = 1'b1;
        if (nf_in) begin
          state_next     = RENDER;
          disp_bank_next = ~disp_bank_reg;
          frames_next    = frames_reg + 16'd1;
        end
      end
      default: state_next = RENDER;
    endcase
  end

  // The renderer always writes the bank that is not on screen.
  assign bank_we = {wr_en && !disp_bank_reg, wr_en && disp_bank_reg};
  // Bank choice is delayed one cycle to line up with the RAM output register.
  assign ram_q   = disp_d_reg ? bank_q[1] : bank_q[0];
`else
  assign wr_ready     = 1'b1;
  assign swap_pending = 1'b0;
  assign bank_we      = wr_en;
  assign ram_q        = bank_q[0];

  // Single bank: every finished frame counts as shown.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) frames_reg <= '0;
    else          frames_reg <= frames_reg + {15'd0, frame_done};
  end
`endif

  // Saturating count of accepted writes that fell outside the region.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      oob_reg <= '0;
    else if (wr_accept && !wr_in_region && oob_reg != 16'hFFFF)
      oob_reg <= oob_reg + 16'd1;
  end

  // Sync/active/in-region flags delayed RD_LAT cycles to match the colour path.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < RD_LAT; i++) fpipe[i] <= '0;
    end else begin
      fpipe[0] <= {hs_in, vs_in, ad_in, rd_in_region};
      for (int i = 1; i < RD_LAT; i++) fpipe[i] <= fpipe[i-1];
    end
  end

  generate
    if (RD_LAT > 1) begin : g_dpipe
      logic [PIX_W-1:0] dpipe [RD_LAT-1];
      // Extra data stages after the RAM register to reach RD_LAT.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int i = 0; i < RD_LAT-1; i++) dpipe[i] <= '0;
        end else begin
          dpipe[0] <= ram_q;
          for (int i = 1; i < RD_LAT-1; i++) dpipe[i] <= dpipe[i-1];
        end
      end
      assign data_out = dpipe[RD_LAT-2];
    end else begin : g_nopipe
      assign data_out = ram_q;
    end
  endgenerate

  // Blank outside active draw, background outside the region, else stored pixel.
  always_comb begin
    colour = '0;
    if (fpipe[RD_LAT-1][1]) colour = fpipe[RD_LAT-1][0] ? data_out : BG_COLOR;
  end

  assign vga_r        = colour[PIX_W-1 -: CHAN_W];
  assign vga_g        = colour[2*CHAN_W-1 -: CHAN_W];
  assign vga_b        = colour[CHAN_W-1:0];
  assign hs_out       = fpipe[RD_LAT-1][3];
  assign vs_out       = fpipe[RD_LAT-1][2];
  assign frames_shown = frames_reg;
  assign oob_drops    = oob_reg;

endmodule

// File: tb/tb_region_framebuffer.sv
// Self-checking bench for region_framebuffer (single- or double-buffered build).
module tb_region_framebuffer;

  localparam int SX = 390, SY = 390, EX = 634, EY = 765, LAT = 2;
  localparam logic [11:0] BG = 12'h5A3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [10:0] wr_hcount = '0, hcount_in = '0;
  logic [9:0]  wr_vcount = '0, vcount_in = '0;
  logic [23:0] wr_pixel = '0;
  logic        wr_valid = 1'b0, frame_done = 1'b0, nf_in = 1'b0;
  logic        hs_in = 1'b1, vs_in = 1'b1, ad_in = 1'b1;
  logic        wr_ready, swap_pending, hs_out, vs_out;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [15:0] frames_shown, oob_drops;
  logic        wr_ready3, swap_pending3, hs_out3, vs_out3;
  logic [3:0]  vga_r3, vga_g3, vga_b3;
  logic [15:0] frames_shown3, oob_drops3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [11:0] mdl_mem [int];
  int mdl_disp = 0, mdl_frames = 0, mdl_drops = 0;
  bit mdl_pending = 0;
  int qx[$], qy[$];

  always #5 aclk = ~aclk;

  region_framebuffer #(.BG_COLOR(BG)) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_hcount(wr_hcount), .wr_vcount(wr_vcount),
    .wr_pixel(wr_pixel), .wr_valid(wr_valid), .wr_ready(wr_ready), .frame_done(frame_done),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hs_in(hs_in), .vs_in(vs_in),
    .ad_in(ad_in), .nf_in(nf_in), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hs_out(hs_out), .vs_out(vs_out), .swap_pending(swap_pending),
    .frames_shown(frames_shown), .oob_drops(oob_drops));

  region_framebuffer #(.BG_COLOR(BG), .RD_LAT(3)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .wr_hcount(wr_hcount), .wr_vcount(wr_vcount),
    .wr_pixel(wr_pixel), .wr_valid(wr_valid), .wr_ready(wr_ready3), .frame_done(frame_done),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hs_in(hs_in), .vs_in(vs_in),
    .ad_in(ad_in), .nf_in(nf_in), .vga_r(vga_r3), .vga_g(vga_g3), .vga_b(vga_b3),
    .hs_out(hs_out3), .vs_out(vs_out3), .swap_pending(swap_pending3),
    .frames_shown(frames_shown3), .oob_drops(oob_drops3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_reg(input int x, input int y);
    return x >= SX && x < EX && y >= SY && y < EY;
  endfunction

  function automatic int mk(input int b, input int x, input int y);
    return b * 2097152 + x * 1024 + y;
  endfunction

  function automatic int wbank();
`ifdef DOUBLE_BUFFER_EN
    return 1 - mdl_disp;
`else
    return 0;
`endif
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0: return 386 + int'($urandom_range(0, 8));
      1: return 630 + int'($urandom_range(0, 8));
      2: return int'($urandom_range(SX, EX - 1));
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom_range(0, 3))
      0: return 386 + int'($urandom_range(0, 8));
      1: return 761 + int'($urandom_range(0, 8));
      2: return int'($urandom_range(SY, EY - 1));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One write (optional) and one read presented in the same cycle; colour checked LAT cycles on.
  task automatic cycle_rw(input bit wv, input int wx, input int wy, input logic [23:0] wp,
                          input int rx, input int ry, input bit rad);
    logic [11:0] exp_col;
    bit known;
    int key;
    known = 1;
    exp_col = 12'h000;
    if (rad && !in_reg(rx, ry)) exp_col = BG;
    else if (rad) begin
      key = mk(mdl_disp, rx, ry);
      known = mdl_mem.exists(key);
      if (known) exp_col = mdl_mem[key];
    end
    check_val("wr_ready", {31'd0, wr_ready}, mdl_pending ? 0 : 1);
    wr_valid = wv; wr_hcount = 11'(wx); wr_vcount = 10'(wy); wr_pixel = wp;
    hcount_in = 11'(rx); vcount_in = 10'(ry); ad_in = rad;
    tick();
    if (wv && !mdl_pending) begin
      if (in_reg(wx, wy)) mdl_mem[mk(wbank(), wx, wy)] = {wp[23:20], wp[15:12], wp[7:4]};
      else if (mdl_drops < 65535) mdl_drops++;
    end
    wr_valid = 1'b0; ad_in = 1'b0;
    repeat (LAT - 1) tick();
    if (known) check_val("colour", {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_col});
    check_val("oob_drops", {16'd0, oob_drops}, mdl_drops);
    $display("rw wr=%0d (%0d,%0d) %h rd=(%0d,%0d) ad=%0d rgb=%h%h%h drops=%0d",
             wv, wx, wy, wp, rx, ry, rad, vga_r, vga_g, vga_b, oob_drops);
  endtask

  task automatic pulse(input bit fd, input bit nf);
    frame_done = fd; nf_in = nf;
    tick();
    frame_done = 1'b0; nf_in = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    if (!mdl_pending) begin
      if (fd) mdl_pending = 1;
    end else if (nf) begin
      mdl_pending = 0;
      mdl_disp = 1 - mdl_disp;
      mdl_frames++;
    end
`else
    if (fd) mdl_frames++;
`endif
    check_val("swap_pending", {31'd0, swap_pending}, mdl_pending ? 1 : 0);
    check_val("wr_ready", {31'd0, wr_ready}, mdl_pending ? 0 : 1);
    check_val("frames_shown", {16'd0, frames_shown}, mdl_frames & 32'hFFFF);
    $display("pulse fd=%0d nf=%0d pending=%0d frames=%0d", fd, nf, swap_pending, frames_shown);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #2;
    mdl_disp = 0; mdl_pending = 0; mdl_frames = 0; mdl_drops = 0;
    check_val("rst_wr_ready", {31'd0, wr_ready}, 1);
    check_val("rst_swap_pending", {31'd0, swap_pending}, 0);
    check_val("rst_frames", {16'd0, frames_shown}, mdl_frames);
    check_val("rst_drops", {16'd0, oob_drops}, mdl_drops);
    check_val("rst_colour", {20'd0, vga_r, vga_g, vga_b}, 0);
    check_val("rst_syncs", {30'd0, hs_out, vs_out}, 0);
    repeat (2) tick();
    aresetn = 1'b1;
    $display("reset applied");
  endtask

  task automatic hsvs_step(input bit h, input bit v);
    bit oh, ov;
    oh = hs_in; ov = vs_in;
    hs_in = h; vs_in = v;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("hs_out", {31'd0, hs_out}, (k >= LAT) ? h : oh);
      check_val("vs_out", {31'd0, vs_out}, (k >= LAT) ? v : ov);
      check_val("hs_out_lat3", {31'd0, hs_out3}, (k >= 3) ? h : oh);
      check_val("vs_out_lat3", {31'd0, vs_out3}, (k >= 3) ? v : ov);
      $display("sync step %0d hs=%0d vs=%0d hs3=%0d vs3=%0d", k, hs_out, vs_out, hs_out3, vs_out3);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();
    hs_in = 1'b0; vs_in = 1'b0; ad_in = 1'b0;
    repeat (4) tick();

    // Corner pixel write and read-back
    cycle_rw(1, 390, 390, 24'hF0A050, 0, 0, 0);
    cycle_rw(0, 0, 0, 24'h0, 390, 390, 1);
    // Out-of-region write must not alias onto (390,401)
    cycle_rw(1, 390, 401, 24'h123456, 0, 0, 0);
    cycle_rw(1, 634, 400, 24'hFFFFFF, 0, 0, 0);
    cycle_rw(0, 0, 0, 24'h0, 390, 401, 1);
    cycle_rw(0, 0, 0, 24'h0, 100, 100, 1);
    cycle_rw(0, 0, 0, 24'h0, 100, 100, 0);
    // Region edges
    cycle_rw(1, 633, 764, 24'h9C5E31, 0, 0, 0);
    cycle_rw(1, 389, 500, 24'h111111, 0, 0, 0);
    cycle_rw(1, 500, 765, 24'h222222, 0, 0, 0);
    cycle_rw(1, 500, 389, 24'h333333, 633, 764, 1);
    // Read-first collision
    cycle_rw(1, 400, 400, 24'hAABBCC, 0, 0, 0);
    cycle_rw(1, 400, 400, 24'h112233, 400, 400, 1);
    cycle_rw(0, 0, 0, 24'h0, 400, 400, 1);

    hsvs_step(1'b1, 1'b0);
    hsvs_step(1'b0, 1'b1);
    hsvs_step(1'b0, 1'b0);

    // Frame handshake sequence, including coincident and ignored pulses
    pulse(1, 0); pulse(1, 0); pulse(0, 1); pulse(1, 1); pulse(0, 1); pulse(0, 1);

`ifdef DOUBLE_BUFFER_EN
    if (mdl_pending) pulse(0, 1);
    cycle_rw(1, 390, 390, 24'h0000F0, 0, 0, 0);
    pulse(1, 0); pulse(0, 1);
    cycle_rw(1, 390, 390, 24'h00F000, 0, 0, 0);
    pulse(1, 0);
    cycle_rw(1, 390, 390, 24'h0F0F0F, 390, 390, 1);
    pulse(1, 0);
    pulse(0, 1);
    cycle_rw(0, 0, 0, 24'h0, 390, 390, 1);
`endif

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        int wx, wy, rx, ry, idx;
        bit wv, rad;
        logic [23:0] wp;
        wx = rand_x(); wy = rand_y();
        wv = ($urandom_range(0, 3) != 0);
        wp = 24'($urandom);
        if (qx.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = int'($urandom_range(0, qx.size() - 1));
          rx = qx[idx]; ry = qy[idx];
        end else begin
          rx = rand_x(); ry = rand_y();
        end
        rad = ($urandom_range(0, 4) != 0);
        cycle_rw(wv, wx, wy, wp, rx, ry, rad);
        if (wv && in_reg(wx, wy)) begin qx.push_back(wx); qy.push_back(wy); end
      end
    end

    // Drop counter saturation
    if (mdl_pending) pulse(0, 1);
    wr_hcount = '0; wr_vcount = '0; wr_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (!mdl_pending && mdl_drops < 65535) mdl_drops++;
    end
    wr_valid = 1'b0;
    check_val("oob_sat", {16'd0, oob_drops}, mdl_drops);
    $display("burst of 65540 out-of-region writes, drops=%0d", oob_drops);
    cycle_rw(1, 0, 0, 24'h0, 0, 0, 0);

    // Reset while a swap is pending (or mid-frame): state clears, RAM survives
    if (!mdl_pending) pulse(1, 0);
    do_reset();
    repeat (2) tick();
    check_val("post_rst_frames", {16'd0, frames_shown}, mdl_frames);
    cycle_rw(0, 0, 0, 24'h0, 390, 390, 1);
    cycle_rw(0, 0, 0, 24'h0, 633, 764, 1);
    for (int i = 0; i < 8 && i < qx.size(); i++) cycle_rw(0, 0, 0, 24'h0, qx[i], qy[i], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/region_framebuffer.md
REGION_FRAMEBUFFER -- requirements
Module: region_framebuffer

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
  START_X 390, first region column;
  START_Y 390, first region row;
  END_X 634, exclusive last column;
  END_Y 765, exclusive last row;
  CHAN_W 4, stored bits per colour channel;
  RD_LAT 2, read-pipeline depth (min 1);
  BG_COLOR 0, 3*CHAN_W value shown outside the region.
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
  aclk  in  1  clock;
  aresetn  in  1  reset;
  wr_hcount  in  11  write pixel column;
  wr_vcount  in  10  write pixel row;
  wr_pixel  in  24  RGB888 write data;
  wr_valid  in  1  write strobe;
  wr_ready  out  1  write accepted;
  frame_done  in  1  renderer finished frame (pulse);
  hcount_in  in  11  VGA column;
  vcount_in  in  10  VGA row;
  hs_in, vs_in, ad_in  in  1 each  syncs and active-draw;
  nf_in  in  1  new-frame pulse;
  vga_r, vga_g, vga_b  out  CHAN_W each  colour;
  hs_out, vs_out  out  1 each  delayed syncs;
  swap_pending  out  1  frame waiting for display;
  frames_shown  out  16  frames swapped in;
  oob_drops  out  16  rejected out-of-region writes.
REQ-003 Clocking SHALL be a single clock, aclk; reset SHALL be aresetn, asynchronous and active-low.

Function
REQ-004 Write address SHALL be (wr_hcount-START_X)+(wr_vcount-START_Y)*(END_X-START_X), with a width of clog2 of the region area (17 bits at defaults).
REQ-005 A write SHALL be accepted when wr_valid&&wr_ready; the stored word SHALL be the top CHAN_W bits of each 8-bit channel; data SHALL be readable one cycle later.
REQ-006 An accepted write outside [START,END) SHALL be dropped and SHALL increment oob_drops, saturating at 0xFFFF.
REQ-007 The read address SHALL use the same formula applied to hcount_in/vcount_in; outside the region the address SHALL be forced to 0.
REQ-008 vga_r/g/b SHALL appear exactly RD_LAT cycles after the hcount/vcount inputs.
REQ-009 hs_out, vs_out and the internal ad/in-region flags SHALL be delayed by RD_LAT cycles so that they stay aligned with the colour outputs.
REQ-010 The colour outputs SHALL be: 0 when the delayed ad_in is low; BG_COLOR when the delayed in-region flag is low; stored data otherwise.
REQ-011 A same-cycle read and write to the same address in the same bank SHALL be read-first: the old data is returned.
REQ-012 The write-side FSM SHALL have states RENDER and WAIT_SWAP.
REQ-013 In RENDER, a frame_done pulse SHALL move the FSM to WAIT_SWAP; in WAIT_SWAP, wr_ready SHALL be 0 and swap_pending SHALL be 1.
REQ-014 In WAIT_SWAP, an nf_in pulse SHALL exchange the display and write banks, increment frames_shown (wrapping), and return the FSM to RENDER.
REQ-015 frame_done coincident with nf_in while in RENDER SHALL NOT swap in that cycle; the swap SHALL occur on the next nf_in.
REQ-016 frame_done received while in WAIT_SWAP SHALL be ignored.
REQ-017 wr_ready SHALL be 1 in RENDER.

Reset
REQ-018 While aresetn is low, the block SHALL hold: the FSM in RENDER; display bank 0, write bank 1; wr_ready 1; swap_pending 0; both counters 0; all delay stages, vga_r/g/b, hs_out and vs_out 0.
REQ-019 Reset SHALL NOT clear RAM contents.
REQ-020 Reset asserted mid-frame or during WAIT_SWAP SHALL abandon the pending swap.

Configuration
REQ-021 With DOUBLE_BUFFER_EN defined, the block SHALL have two banks and behave per REQ-012..REQ-017.
REQ-022 Without DOUBLE_BUFFER_EN, the block SHALL have a single bank shared by reads and writes, with the FSM fixed in RENDER, wr_ready constantly 1 and swap_pending constantly 0.
REQ-023 Without DOUBLE_BUFFER_EN, frames_shown SHALL increment on each frame_done pulse.

Structure
REQ-024 Package fb_pkg SHALL hold: HCOUNT_W=11; VCOUNT_W=10; the rgb888_t typedef; the fb_state_t enum (RENDER, WAIT_SWAP); the address-width function.
REQ-025 A sub-module fb_bank_ram SHALL implement one read-first, single-clock simple dual-port RAM with a registered output; it SHALL be instantiated once or twice depending on DOUBLE_BUFFER_EN.

Verification
REQ-026 Bench case: write 0xF0A050 at (390,390), then read hcount/vcount (390,390) with ad_in=1 -> after 2 cycles, vga_r/g/b = F,A,5.
REQ-027 Bench case: write at (634,400) -> oob_drops=1, RAM unchanged; reading (100,100) with ad_in=1 -> BG_COLOR; with ad_in=0 -> 0.
REQ-028 Bench case: toggle hs_in/vs_in -> hs_out/vs_out toggle exactly RD_LAT cycles later; repeat with RD_LAT=3.
REQ-029 Bench case (DOUBLE_BUFFER_EN): bank 1 is filled with 0x00F000 and frame_done is pulsed -> wr_ready goes 0 and the display still shows bank 0; on nf_in -> display shows green, frames_shown=1, wr_ready=1.
REQ-030 Bench case (DOUBLE_BUFFER_EN): frame_done and nf_in pulsed in the same cycle -> no swap; swap occurs on the next nf_in.
REQ-031 Bench case: aresetn is pulsed low while in WAIT_SWAP -> FSM returns to RENDER, swap_pending=0, counters=0, and RAM data survives.
